count_seq_checker: RTL and testbench

Receive-side checker for the bounded counter stream produced by the team's "count to MAX and no higher" counters. It samples a counter value each valid cycle and enforces the legal sequence: start at 0, step by exactly +1 up to MAX, then hold at MAX. Violations are flagged, classified and counted. The block sits beside the counter as an in-design monitor and drives the local status/interrupt logic.

---
 rtl/count_pkg.sv | 23 ++
 rtl/count_seq_checker_sat_counter.sv | 23 ++
 rtl/count_seq_checker.sv | 121 ++++++++++++
 tb/tb_count_seq_checker.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/count_pkg.sv
// Shared definitions for the bounded counter and its receive-side checker:
// checker states, violation classes and the default counter geometry.
package count_pkg;

   localparam int DEF_WIDTH = 3;
   localparam int DEF_MAX   = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_SAT  = 2'd2
   } state_t;

   typedef enum logic [2:0] {
      ERR_NONE  = 3'd0,
      ERR_RANGE = 3'd1,
      ERR_START = 3'd2,
      ERR_STALL = 3'd3,
      ERR_SKIP  = 3'd4,
      ERR_DROP  = 3'd5
   } err_code_t;

endpackage

// File: rtl/count_seq_checker_sat_counter.sv
// Generic saturating up-counter with synchronous clear; a clear coinciding
// with an increment leaves the count at one.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= inc ? W'(1) : '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/count_seq_checker.sv
// In-design monitor for a "count to MAX and hold" counter stream: checks each
// valid sample against the legal 0,1,..,MAX,MAX.. sequence and classifies faults.
//
//   state   | meaning
//   --------+----------------------------------------------
//   ST_IDLE | expecting the first sample, which must be 0
//   ST_RUN  | last legal value L < MAX, expecting L+1
//   ST_SAT  | last value was MAX, expecting MAX forever
module count_seq_checker
   import count_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int MAX      = DEF_MAX,
   parameter int ERRCNT_W = 8
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                in_valid,
   input  logic [WIDTH-1:0]    in_count,
   input  logic                err_clr,
   output logic                err_pulse,
   output logic [2:0]          err_code,
   output logic                err_sticky,
   output logic [ERRCNT_W-1:0] err_count,
   output logic                at_max,
   output logic                max_pulse
);

   localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] last, last_nxt;
   err_code_t        code;
   logic             max_step;
   logic             err_hit;
   logic [WIDTH:0]   last_inc;

   assign last_inc = {1'b0, last} + (WIDTH+1)'(1);

   always_comb begin
      state_nxt = state;
      last_nxt  = last;
      code      = ERR_NONE;
      max_step  = 1'b0;
      if (in_valid) begin
         if (in_count > MAXV) begin
            code      = ERR_RANGE;
            state_nxt = ST_IDLE;
            last_nxt  = '0;
         end else begin
            unique case (state)
               ST_IDLE: begin
                  if (in_count == '0) begin
                     state_nxt = ST_RUN;
                     last_nxt  = '0;
                  end else begin
                     code = ERR_START;
                  end
               end
               ST_RUN: begin
                  if ({1'b0, in_count} == last_inc) begin
                     last_nxt = in_count;
                     if (in_count == MAXV) begin
                        state_nxt = ST_SAT;
                        max_step  = 1'b1;
                     end
                  end else if (in_count == last) begin
                     code = ERR_STALL;
                  end else begin
                     code = ERR_SKIP;
                  end
               end
               ST_SAT: begin
                  if (in_count != MAXV) code = ERR_DROP;
               end
               default: state_nxt = ST_IDLE;
            endcase
            // In-sequence faults resync onto the observed value; START keeps waiting for 0.
            if ((code != ERR_NONE) && (code != ERR_START)) begin
               last_nxt  = in_count;
               state_nxt = (in_count == MAXV) ? ST_SAT : ST_RUN;
            end
         end
      end
   end

   assign err_hit = (code != ERR_NONE);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state      <= ST_IDLE;
         last       <= '0;
         err_pulse  <= 1'b0;
         max_pulse  <= 1'b0;
         err_code   <= ERR_NONE;
         err_sticky <= 1'b0;
      end else begin
         state     <= state_nxt;
         last      <= last_nxt;
         err_pulse <= err_hit;
         max_pulse <= max_step;
         if (err_hit) begin
            err_code   <= code;
            err_sticky <= 1'b1;
         end else if (err_clr) begin
            err_sticky <= 1'b0;
         end
      end
   end

   assign at_max = (state == ST_SAT);

   sat_counter #(.W(ERRCNT_W)) u_err_cnt (
      .clk    (clk),
      .resetn (resetn),
      .clr    (err_clr),
      .inc    (err_hit),
      .cnt    (err_count)
   );

endmodule

// File: tb/tb_count_seq_checker.sv
// Table-driven bench for count_seq_checker (MAX=3, ERRCNT_W=2) with an
// expected-output queue, plus a hand-timed max_pulse sequence.
module tb_count_seq_checker;
   import count_pkg::*;

   logic       clk = 1'b0;
   logic       resetn;
   logic       in_valid;
   logic [2:0] in_count;
   logic       err_clr;
   logic       err_pulse;
   logic [2:0] err_code;
   logic       err_sticky;
   logic [1:0] err_count;
   logic       at_max;
   logic       max_pulse;

   count_seq_checker #(.WIDTH(3), .MAX(3), .ERRCNT_W(2)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .in_valid   (in_valid),
      .in_count   (in_count),
      .err_clr    (err_clr),
      .err_pulse  (err_pulse),
      .err_code   (err_code),
      .err_sticky (err_sticky),
      .err_count  (err_count),
      .at_max     (at_max),
      .max_pulse  (max_pulse)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       valid;
      logic [2:0] cnt;
      logic       clr;
      logic       ep;
      logic       mp;
      logic [2:0] code;
      logic       st;
      logic [1:0] ecnt;
      logic       am;
   } vec_t;

   vec_t       vecs[$];
   logic [8:0] exp_q[$];
   int         checks = 0;
   int         errors = 0;

   function automatic void add(input logic rst, input logic valid, input logic [2:0] cnt,
                               input logic clr, input logic ep, input logic mp,
                               input logic [2:0] code, input logic st,
                               input logic [1:0] ecnt, input logic am);
      vec_t v;
      v.rst = rst; v.valid = valid; v.cnt = cnt; v.clr = clr;
      v.ep = ep; v.mp = mp; v.code = code; v.st = st; v.ecnt = ecnt; v.am = am;
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got ep,mp,code,st,cnt,am=%b required %b", name, got, exp);
      end
   endtask

   task automatic step(input vec_t v, input int idx);
      logic [8:0] exp;
      resetn   = ~v.rst;
      in_valid = v.valid;
      in_count = v.cnt;
      err_clr  = v.clr;
      exp_q.push_back({v.ep, v.mp, v.code, v.st, v.ecnt, v.am});
      @(posedge clk);
      #1;
      exp = exp_q.pop_front();
      check($sformatf("row%0d", idx),
            {err_pulse, max_pulse, err_code, err_sticky, err_count, at_max}, exp);
   endtask

   task automatic drive(input logic v, input logic [2:0] c);
      resetn = 1'b1; in_valid = v; in_count = c; err_clr = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int seen;
      resetn = 1'b0; in_valid = 1'b0; in_count = '0; err_clr = 1'b0;
      //  rst v cnt clr | ep mp code st ecnt am
      // legal run
      add(1,0,0,0, 0,0,0,0,0,0);
      add(0,1,0,0, 0,0,0,0,0,0);
      add(0,1,1,0, 0,0,0,0,0,0);
      add(0,1,2,0, 0,0,0,0,0,0);
      add(0,1,3,0, 0,1,0,0,0,1);
      add(0,1,3,0, 0,0,0,0,0,1);
      add(0,1,3,0, 0,0,0,0,0,1);
      // drop and resync
      add(1,0,0,0, 0,0,0,0,0,0);
      add(0,1,0,0, 0,0,0,0,0,0);
      add(0,1,1,0, 0,0,0,0,0,0);
      add(0,1,2,0, 0,0,0,0,0,0);
      add(0,1,3,0, 0,1,0,0,0,1);
      add(0,1,2,0, 1,0,5,1,1,0);
      add(0,1,3,0, 0,1,5,1,1,1);
      // range and start, stay idle
      add(1,0,0,0, 0,0,0,0,0,0);
      add(0,1,5,0, 1,0,1,1,1,0);
      add(0,1,2,0, 1,0,2,1,2,0);
      add(0,1,0,0, 0,0,2,1,2,0);
      add(0,1,1,0, 0,0,2,1,2,0);
      // stall and skip
      add(1,0,0,0, 0,0,0,0,0,0);
      add(0,1,0,0, 0,0,0,0,0,0);
      add(0,1,1,0, 0,0,0,0,0,0);
      add(0,1,1,0, 1,0,3,1,1,0);
      add(0,1,3,0, 1,0,4,1,2,1);
      add(0,1,3,0, 0,0,4,1,2,1);
      // saturation and clear
      add(1,0,0,0, 0,0,0,0,0,0);
      add(0,1,1,0, 1,0,2,1,1,0);
      add(0,1,1,0, 1,0,2,1,2,0);
      add(0,1,1,0, 1,0,2,1,3,0);
      add(0,1,1,0, 1,0,2,1,3,0);
      add(0,1,1,0, 1,0,2,1,3,0);
      add(0,1,1,1, 1,0,2,1,1,0);
      add(0,0,0,1, 0,0,2,0,0,0);
      // gaps with garbage on the bus, then mid-run reset
      add(1,0,0,0, 0,0,0,0,0,0);
      add(0,1,0,0, 0,0,0,0,0,0);
      add(0,0,3,0, 0,0,0,0,0,0);
      add(0,0,7,0, 0,0,0,0,0,0);
      add(0,0,2,0, 0,0,0,0,0,0);
      add(0,0,0,0, 0,0,0,0,0,0);
      add(0,1,1,0, 0,0,0,0,0,0);
      add(0,1,2,0, 0,0,0,0,0,0);
      add(1,0,0,0, 0,0,0,0,0,0);
      add(0,1,2,0, 1,0,2,1,1,0);
      add(0,1,3,0, 1,0,2,1,2,0);

      @(negedge clk);
      foreach (vecs[i]) step(vecs[i], i);

      // max_pulse lands exactly one cycle after the MAX sample and lasts one cycle
      resetn = 1'b0; in_valid = 1'b0;
      @(posedge clk); #1;
      drive(1, 0); drive(1, 1); drive(1, 2);
      resetn = 1'b1; in_valid = 1'b1; in_count = 3'd3;
      @(posedge clk); #1;
      in_valid = 1'b0;
      seen = -1;
      for (int c = 0; c < 4; c++) begin
         if (max_pulse === 1'b1) begin
            seen = c;
            break;
         end
         @(posedge clk); #1;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL max_pulse_latency got %0d required 0", seen);
      end
      @(posedge clk); #1;
      check("max_pulse_one_cycle", {err_pulse, max_pulse, err_code, err_sticky, err_count, at_max},
            9'b0_0_000_0_00_1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
